// File: rtl/mask_packer_if.sv
// Pixel-in / mask-word-out bundle of the camera mask packer.
// MASK_PIXEL_COUNT_EN adds the per-frame pixelCount result.
interface mask_packer_if #(
    parameter int ADDR_WIDTH = 14
);
    logic                  enable;
    logic                  frameStart;
    logic                  lineEnd;
    logic                  pixelValid;
    logic [15:0]           pixelData;
    logic [15:0]           thresholdMin;
    logic [15:0]           thresholdMax;
    logic [ADDR_WIDTH-1:0] maskAddress;
    logic [31:0]           maskData;
    logic                  maskWe;
    logic                  frameDone;
    logic                  overflow;
`ifdef MASK_PIXEL_COUNT_EN
    logic [18:0]           pixelCount;

    modport master (
        output enable, frameStart, lineEnd, pixelValid, pixelData, thresholdMin, thresholdMax,
        input  maskAddress, maskData, maskWe, frameDone, overflow, pixelCount
    );
    modport slave (
        input  enable, frameStart, lineEnd, pixelValid, pixelData, thresholdMin, thresholdMax,
        output maskAddress, maskData, maskWe, frameDone, overflow, pixelCount
    );
`else
    modport master (
        output enable, frameStart, lineEnd, pixelValid, pixelData, thresholdMin, thresholdMax,
        input  maskAddress, maskData, maskWe, frameDone, overflow
    );
    modport slave (
        input  enable, frameStart, lineEnd, pixelValid, pixelData, thresholdMin, thresholdMax,
        output maskAddress, maskData, maskWe, frameDone, overflow
    );
`endif
endinterface

// File: rtl/mask_packer.sv
// Classifies RGB565 pixels against per-channel thresholds and packs the mask bits into 32-bit words.
// Optional MASK_PIXEL_COUNT_EN reports the number of mask-1 pixels written per closed frame.
module mask_packer #(
    parameter int NR_OF_WORDS = 9600,
    parameter int ADDR_WIDTH  = 14
) (
    input logic          clock,
    input logic          nReset,
    mask_packer_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, FULL = 2'd2} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NR_OF_WORDS - 1);

    state_t                r_state, w_stateNext;
    logic [31:0]           r_shift, w_shiftBase, w_shiftNext, w_word;
    logic [4:0]            r_cnt, w_cntBase, w_cntNext;
    logic [ADDR_WIDTH-1:0] r_addr, w_addrBase, w_addrNext;
    logic [ADDR_WIDTH-1:0] r_maskAddress;
    logic [31:0]           r_maskData;
    logic                  r_maskWe, r_frameDone, r_overflow;
    logic                  w_run, w_restart, w_pixBit, w_write, w_lastWrite, w_overflowNext;

    function automatic logic f_chanMatch(input logic [5:0] v, input logic [5:0] mn, input logic [5:0] mx);
        return (v >= mn) && (v <= mx);
    endfunction

    function automatic logic f_pixMatch(input logic [15:0] p, input logic [15:0] mn, input logic [15:0] mx);
        return f_chanMatch({1'b0, p[15:11]}, {1'b0, mn[15:11]}, {1'b0, mx[15:11]})
            && f_chanMatch(p[10:5], mn[10:5], mx[10:5])
            && f_chanMatch({1'b0, p[4:0]}, {1'b0, mn[4:0]}, {1'b0, mx[4:0]});
    endfunction

    always_ff @(posedge clock) begin
        if (!nReset) r_state <= IDLE;
        else         r_state <= w_stateNext;
    end

    always_comb begin
        w_stateNext = r_state;
        if (w_lastWrite)         w_stateNext = FULL;
        else if (bus.frameStart) w_stateNext = bus.enable ? ACTIVE : IDLE;
    end

    // frameStart wipes the running frame first; the same cycle's pixel then lands in the new one.
    always_comb begin
        w_restart   = bus.frameStart && (r_state != IDLE);
        w_run       = bus.frameStart ? bus.enable : (r_state == ACTIVE);
        w_cntBase   = bus.frameStart ? 5'd0 : r_cnt;
        w_shiftBase = bus.frameStart ? 32'd0 : r_shift;
        w_addrBase  = bus.frameStart ? '0 : r_addr;
        w_pixBit    = f_pixMatch(bus.pixelData, bus.thresholdMin, bus.thresholdMax);
        w_word      = w_shiftBase;
        w_cntNext   = w_cntBase;
        w_shiftNext = w_shiftBase;
        w_addrNext  = w_addrBase;
        w_write     = 1'b0;
        w_lastWrite = 1'b0;
        if (w_run) begin
            if (bus.pixelValid) begin
                w_word    = w_shiftBase | (32'(w_pixBit) << w_cntBase);
                w_cntNext = w_cntBase + 5'd1;
            end
            w_write = (bus.pixelValid && (w_cntBase == 5'd31))
                   || (bus.lineEnd && (bus.pixelValid || (w_cntBase != 5'd0)));
            if (w_write) begin
                w_lastWrite = (w_addrBase == LAST_ADDR);
                w_cntNext   = 5'd0;
                w_shiftNext = 32'd0;
                // Address parks on the last word once the store is full.
                w_addrNext  = w_lastWrite ? w_addrBase : w_addrBase + ADDR_WIDTH'(1);
            end else begin
                w_shiftNext = w_word;
            end
        end
        w_overflowNext = bus.frameStart ? 1'b0
                       : (r_overflow || ((r_state == FULL) && bus.pixelValid));
    end

    always_ff @(posedge clock) begin
        if (!nReset) begin
            r_shift       <= '0;
            r_cnt         <= '0;
            r_addr        <= '0;
            r_maskAddress <= '0;
            r_maskData    <= '0;
            r_maskWe      <= 1'b0;
            r_frameDone   <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_shift     <= w_shiftNext;
            r_cnt       <= w_cntNext;
            r_addr      <= w_addrNext;
            r_maskWe    <= w_write;
            r_frameDone <= w_restart || w_lastWrite;
            r_overflow  <= w_overflowNext;
            if (w_write) begin
                r_maskAddress <= w_addrBase;
                r_maskData    <= w_word;
            end
        end
    end

    assign bus.maskAddress = r_maskAddress;
    assign bus.maskData    = r_maskData;
    assign bus.maskWe      = r_maskWe;
    assign bus.frameDone   = r_frameDone;
    assign bus.overflow    = r_overflow;

`ifdef MASK_PIXEL_COUNT_EN
    logic [18:0] r_popAcc, r_pixelCount, w_pop;

    assign w_pop = w_write ? 19'($countones(w_word)) : 19'd0;

    // On a restart the accumulator holds only the closed frame; any write this cycle belongs to the new one.
    always_ff @(posedge clock) begin
        if (!nReset) begin
            r_popAcc     <= '0;
            r_pixelCount <= '0;
        end else if (w_restart) begin
            r_pixelCount <= r_popAcc;
            r_popAcc     <= w_pop;
        end else if (w_lastWrite) begin
            r_pixelCount <= r_popAcc + w_pop;
            r_popAcc     <= '0;
        end else begin
            r_popAcc <= r_popAcc + w_pop;
        end
    end

    assign bus.pixelCount = r_pixelCount;
`endif
endmodule

// File: tb/tb_mask_packer.sv
// Randomized and directed bench for mask_packer against a queue-based frame model.
// Build with MASK_PIXEL_COUNT_EN to also check pixelCount.
module tb_mask_packer;
    localparam int NW = 24;
    localparam int AW = 14;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mask_packer_if #(.ADDR_WIDTH(AW)) bus();
    mask_packer #(.NR_OF_WORDS(NW), .ADDR_WIDTH(AW)) dut (.clock(clk), .nReset(rst_n), .bus(bus));

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: mode 0 idle, 1 collecting, 2 store full.
    int          m_mode;
    bit          m_q[$];
    int          m_words;
    bit          m_ovf;
    int          m_acc;
    logic        e_we, e_done, e_ovf;
    logic [AW-1:0] e_addr;
    logic [31:0] e_data;
    int          e_pc;

    int          n_writes;
    logic [31:0] last_data;
    logic [AW-1:0] last_addr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit ref_match(input logic [15:0] p, input logic [15:0] mn, input logic [15:0] mx);
        int sh[3] = '{11, 5, 0};
        int wd[3] = '{5, 6, 5};
        for (int c = 0; c < 3; c++) begin
            int v, lo, hi, m;
            m  = (1 << wd[c]) - 1;
            v  = (int'(p)  >> sh[c]) & m;
            lo = (int'(mn) >> sh[c]) & m;
            hi = (int'(mx) >> sh[c]) & m;
            if (v < lo || v > hi) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_q.delete(); m_words = 0; m_ovf = 0; m_acc = 0;
        e_we = 0; e_done = 0; e_ovf = 0; e_addr = '0; e_data = '0; e_pc = 0;
    endtask

    task automatic model_step(input logic fs, input logic le, input logic pv, input logic [15:0] pix);
        e_we = 0; e_done = 0;
        if (fs) begin
            if (m_mode != 0) begin
                e_done = 1; e_pc = m_acc;
            end
            m_acc = 0; m_q.delete(); m_words = 0; m_ovf = 0;
            m_mode = bus.enable ? 1 : 0;
        end else if (m_mode == 2 && pv) begin
            m_ovf = 1;
        end
        if (m_mode == 1) begin
            if (pv) m_q.push_back(ref_match(pix, bus.thresholdMin, bus.thresholdMax));
            if (m_q.size() == 32 || (le && m_q.size() > 0)) begin
                logic [31:0] d;
                d = '0;
                for (int i = 0; i < m_q.size(); i++) if (m_q[i]) d[i] = 1'b1;
                e_we = 1; e_addr = AW'(m_words); e_data = d;
                m_acc += $countones(d);
                m_q.delete();
                m_words++;
                if (m_words == NW) begin
                    m_mode = 2; e_done = 1; e_pc = m_acc; m_acc = 0;
                end
            end
        end
        e_ovf = m_ovf;
    endtask

    task automatic cyc(input logic fs, input logic le, input logic pv, input logic [15:0] pix);
        bus.frameStart = fs;
        bus.lineEnd    = le;
        bus.pixelValid = pv;
        bus.pixelData  = pix;
        if (!rst_n) model_reset();
        else        model_step(fs, le, pv, pix);
        @(posedge clk);
        #1;
        chk("maskWe", 64'(bus.maskWe), 64'(e_we));
        chk("frameDone", 64'(bus.frameDone), 64'(e_done));
        chk("overflow", 64'(bus.overflow), 64'(e_ovf));
        chk("maskAddress", 64'(bus.maskAddress), 64'(e_addr));
        chk("maskData", 64'(bus.maskData), 64'(e_data));
`ifdef MASK_PIXEL_COUNT_EN
        chk("pixelCount", 64'(bus.pixelCount), 64'(e_pc));
`endif
        if (bus.maskWe) begin
            n_writes++;
            last_data = bus.maskData;
            last_addr = bus.maskAddress;
        end
    endtask

    function automatic logic [15:0] pick_pix();
        case ($urandom_range(3))
            0:       return bus.thresholdMin;
            1:       return bus.thresholdMax;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        logic [15:0] mx;
        bus.enable = 1'b1;
        bus.thresholdMin = 16'h0000;
        bus.thresholdMax = 16'hFFFF;
        bus.frameStart = 0; bus.lineEnd = 0; bus.pixelValid = 0; bus.pixelData = 0;
        model_reset();
        n_writes = 0;

        // Reset held with pixels and a frameStart driven
        rst_n = 1'b0;
        cyc(1, 0, 1, 16'($urandom));
        cyc(0, 0, 1, 16'($urandom));
        cyc(0, 1, 1, 16'($urandom));
        rst_n = 1'b1;

        // Full-match word, then a second word
        cyc(1, 0, 0, 16'h0);
        n_writes = 0;
        for (int i = 0; i < 32; i++) cyc(0, 0, 1, 16'($urandom));
        chk("full_writes", 64'(n_writes), 64'd1);
        chk("full_data", 64'(last_data), 64'hFFFF_FFFF);
        chk("full_addr", 64'(last_addr), 64'd0);
        for (int i = 0; i < 32; i++) cyc(0, 0, 1, 16'($urandom));
        chk("second_addr", 64'(last_addr), 64'd1);

        // Bit order and partial flush; only 0x0000 matches
        bus.thresholdMax = 16'h0000;
        cyc(1, 0, 0, 16'h0);
        n_writes = 0;
        cyc(0, 0, 1, 16'h0000);
        cyc(0, 0, 1, 16'hFFFF);
        cyc(0, 0, 1, 16'hFFFF);
        cyc(0, 0, 1, 16'h0000);
        cyc(0, 1, 1, 16'hFFFF);
        chk("partial_data", 64'(last_data), 64'h9);
        chk("partial_addr", 64'(last_addr), 64'd0);
        for (int i = 0; i < 32; i++) cyc(0, 0, 1, 16'h0000);
        chk("after_flush_data", 64'(last_data), 64'hFFFF_FFFF);
        chk("after_flush_addr", 64'(last_addr), 64'd1);
        chk("after_flush_writes", 64'(n_writes), 64'd2);

        // Full frame: 12 lines of 64 pixels fill the NW-word store
        bus.thresholdMax = 16'hFFFF;
        cyc(1, 0, 0, 16'h0);
        n_writes = 0;
        for (int l = 0; l < 12; l++)
            for (int p = 0; p < 64; p++) cyc(0, (p == 63), 1, 16'($urandom));
        chk("frame_writes", 64'(n_writes), 64'(NW));
        chk("frame_last_addr", 64'(last_addr), 64'(NW - 1));
        cyc(0, 0, 1, 16'($urandom));
        chk("extra_overflow", 64'(bus.overflow), 64'd1);
        chk("extra_no_we", 64'(n_writes), 64'(NW));
        cyc(0, 1, 1, 16'($urandom));

        // Mid-frame restart with a pixel in the restart cycle
        bus.thresholdMax = 16'h0000;
        cyc(1, 0, 0, 16'h0);
        n_writes = 0;
        for (int i = 0; i < 40; i++) cyc(0, 0, 1, 16'hFFFF);
        cyc(1, 0, 1, 16'h0000);
        chk("restart_done", 64'(bus.frameDone), 64'd1);
        chk("restart_no_partial", 64'(n_writes), 64'd1);
        for (int i = 0; i < 31; i++) cyc(0, 0, 1, 16'hFFFF);
        chk("restart_data", 64'(last_data), 64'h1);
        chk("restart_addr", 64'(last_addr), 64'd0);

        // 64 pixels with 37 matches (R <= 15)
        bus.thresholdMax = 16'h7FFF;
        cyc(1, 0, 0, 16'h0);
        for (int i = 0; i < 64; i++) cyc(0, 0, 1, (i % 64 < 37) ? 16'h1234 : 16'hF000);
        cyc(1, 0, 0, 16'h0);
`ifdef MASK_PIXEL_COUNT_EN
        chk("pixel_count_37", 64'(bus.pixelCount), 64'd37);
`endif

        // Disabled: frameStart closes and stays idle
        bus.enable = 1'b0;
        cyc(1, 0, 0, 16'h0);
        for (int i = 0; i < 40; i++) cyc(0, (i == 20), 1, 16'h0000);
        bus.enable = 1'b1;

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            logic fs;
            fs = ($urandom_range(199) == 0);
            if (fs && $urandom_range(1) == 0) begin
                mx = 16'($urandom);
                bus.thresholdMax = mx;
                bus.thresholdMin = ($urandom_range(3) == 0) ? 16'($urandom) : (16'($urandom) & mx);
            end
            if (fs) bus.enable = ($urandom_range(9) != 0);
            rst_n = ($urandom_range(799) != 0);
            cyc(fs, ($urandom_range(39) == 0), ($urandom_range(9) < 7), pick_pix());
            rst_n = 1'b1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/mask_packer.md
Name: mask_packer

Overview:
- Upstream stage of the camera mask memory.
- Classifies each incoming RGB565 pixel against programmable per-channel min/max thresholds and produces a 1-bit mask value per pixel.
- Packs 32 mask bits per word and generates write address, data and write-enable for the 9600 x 32-bit mask store (one 640x480 binary frame).
- Runs in the camera pixel clock domain.

Parameters:
NR_OF_WORDS, 9600, words per frame; write address range is 0..NR_OF_WORDS-1
ADDR_WIDTH, 14, width of the write address

Ports:
clock  input  1  pixel clock; all logic on rising edge
nReset  input  1  synchronous reset, active-low
enable  input  1  1 = process frames; 0 = finish nothing new, stay IDLE at next frameStart
frameStart  input  1  one-cycle pulse before first pixel of a frame
lineEnd  input  1  one-cycle pulse with or after last pixel of a line
pixelValid  input  1  pixel qualifier
pixelData  input  16  RGB565 pixel: R=[15:11], G=[10:5], B=[4:0]
thresholdMin  input  16  RGB565 per-channel inclusive lower bounds
thresholdMax  input  16  RGB565 per-channel inclusive upper bounds
maskAddress  output  ADDR_WIDTH  word address to mask memory
maskData  output  32  packed mask word
maskWe  output  1  one-cycle write strobe
frameDone  output  1  one-cycle pulse when a frame is closed
overflow  output  1  sticky per frame: pixels arrived after the last word was written

Behaviour:
- Reset (nReset=0 at a rising edge): state IDLE; shift register, bit counter and word address all 0. Outputs: maskAddress=0, maskData=0, maskWe=0, frameDone=0, overflow=0. Reset mid-frame abandons the frame; no write is issued.
- Mask bit:
  - Bit = 1 iff R, G and B each lie within [min, max] inclusive.
  - Comparisons are unsigned, per channel field.
  - If min > max for a channel, that channel never matches.
- Packing:
  - The k-th valid pixel of a word (k = 0..31) goes to bit k, LSB first.
  - The bit counter is 5 bits and wraps at 32.
- Write timing:
  - When the 32nd bit is accepted at edge t, maskWe=1 during cycle t+1, carrying the full word and the current address.
  - The address increments after the write; the counter and shift register clear.
  - Pipeline latency is one cycle; all outputs are registered.
- Line end:
  - If lineEnd=1 and the counter is non-zero (including the pixel accepted in the same cycle), the partial word is written with unfilled upper bits = 0, then the counter clears.
  - If the counter is 0, there is no write.
  - pixelValid and lineEnd in the same cycle: the pixel is included before the flush.
- States:
  - IDLE: ignore pixels; go to ACTIVE on frameStart && enable.
  - ACTIVE: pack and write as described. Go to FULL when a write to address NR_OF_WORDS-1 completes.
  - FULL: writes suppressed. Any pixelValid sets overflow=1. Go to ACTIVE on the next frameStart && enable, otherwise IDLE on frameStart.
- frameStart in ACTIVE or FULL:
  - Closes the current frame; a pending partial word is discarded.
  - frameDone pulses for one cycle.
  - Address, counter and overflow clear.
  - If enable=1, the new frame starts in that same cycle.
- frameStart and pixelValid in the same cycle: the frame restart takes priority; the pixel becomes bit 0 of the new frame.
- frameDone also pulses on the transition into FULL.
- maskWe is never asserted in IDLE or FULL. The address never exceeds NR_OF_WORDS-1.

Optional Feature:
- Macro: MASK_PIXEL_COUNT_EN.
- When defined:
  - Extra output pixelCount, 19 bits: number of mask-1 pixels written in the last closed frame.
  - An internal counter increments by the popcount of each written word.
  - It is copied to pixelCount on each frameDone pulse, then cleared.
  - Reset value is 0.
  - Pixels discarded at frameStart or in FULL are not counted.
- When undefined: neither the port nor the counter exists; all other behaviour is identical.

Test Plan:
- Reset: hold nReset=0 for 3 cycles while driving pixels -> all outputs 0, no maskWe.
- Full-match word: thresholds min=0x0000, max=0xFFFF, frameStart, then 32 valid pixels -> a single maskWe one cycle after the 32nd pixel, maskAddress=0, maskData=0xFFFFFFFF; the next word goes to address 1.
- Bit order and partial flush: 5 pixels matching only on pixels 0 and 3, then lineEnd -> maskData=0x00000009 at address 0; the counter restarts at 0.
- Full frame: 640x480 matching pixels with lineEnd per line -> exactly 9600 writes at addresses 0..9599, then frameDone. One extra pixel afterwards -> overflow=1 and no maskWe.
- Mid-frame restart: 40 pixels (1 write), then frameStart with pixelValid in the same cycle -> frameDone pulse, no write of the 8-bit partial; the next word is written at address 0 with that pixel in bit 0.
- MASK_PIXEL_COUNT_EN: a frame of 64 pixels with 37 matches, then frameStart -> pixelCount=37 after frameDone.
